dummy_sink_mon: RTL and testbench
=================================

Name: dummy_sink_mon

Overview:
- Parametrised successor to the single-bit input sink used to terminate unused wrapper ports in the co-simulation model.
- Absorbs NUM_CH channels of CH_WIDTH bits each. Instead of discarding them, it records per-channel change counts, a sticky activity flag and the last sampled value.
- The co-sim host reads these through a simple registered read port.
- Sits in the RTL wrapper layer beside the USB core; it drives nothing back into the core.

Parameters:
- NUM_CH, 4, number of monitored input channels (1..16).
- CH_WIDTH, 8, bits per channel (1..32).
- CNT_WIDTH, 16, change-counter width per channel (2..32).
- CLR_ON_READ, 0, 1 = a read clears the addressed channel's counter and activity flag.
- AW, 4, read-address width; must satisfy 2**AW >= NUM_CH.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  NUM_CH*CH_WIDTH  monitored inputs; channel k occupies bits [k*CH_WIDTH +: CH_WIDTH].
- sample_en  in  1  1 = sample and compare inputs this cycle.
- clr  in  1  synchronous clear of all counters, flags and prime state.
- rd_en  in  1  read strobe.
- rd_addr  in  AW  channel index to read.
- rd_valid  out  1  read data valid, one-cycle pulse.
- rd_cnt  out  CNT_WIDTH  change count of addressed channel.
- rd_last  out  CH_WIDTH  last sampled value of addressed channel.
- rd_act  out  1  sticky activity flag of addressed channel.
- act_any  out  1  OR of all activity flags, registered.

Behaviour:
- Reset (rst=1, synchronous), next edge: all counters 0, all last values 0, activity flags 0, primed 0, rd_valid 0, rd_cnt 0, rd_last 0, rd_act 0, act_any 0. rst overrides every other input.
- Sampling applies per channel k on each edge with sample_en=1:
  - last[k] <= in[k].
  - If primed=0: no count this cycle; primed <= 1. The first sample after reset or clr only loads the last value.
  - If primed=1 and in[k] != last[k]: cnt[k] increments and act[k] <= 1.
- Counters saturate at 2**CNT_WIDTH-1 and never wrap.
- sample_en=0: no state changes except reads.
- clr=1: counters, flags and primed go to 0; last values are kept. A change detected in the same cycle is dropped, so clr wins.
- Read timing:
  - rd_en=1 at edge N: rd_cnt, rd_last and rd_act are registered from the pre-update state of channel rd_addr. rd_valid=1 after edge N.
  - Latency is 1 cycle.
  - rd_valid deasserts the following cycle unless rd_en is held. Back-to-back reads are supported, one result per cycle.
- Out-of-range read (rd_addr >= NUM_CH): rd_valid=1, rd_cnt=0, rd_last=0, rd_act=0; no state is affected.
- CLR_ON_READ=1:
  - The addressed channel's cnt and act clear at the read edge.
  - If the same channel also changes that cycle, the read returns the old value, then cnt=1 and act=1 after the edge. The event is not lost.
- Read and clr in the same cycle: the read returns pre-clear values.
- act_any is a registered OR of the act flags and lags the flag update by 1 cycle.
- rd_* outputs hold their last value when rd_valid=0.
- Reset mid-read: rd_valid=0 on the next edge; the pending result is discarded.

Test Plan:
1. Reset, then sample_en=1 with ch0 holding 0x5A for 3 cycles → first cycle primes only. Read ch0 → rd_cnt=0, rd_last=0x5A, rd_act=0.
2. After priming, toggle ch2 0x00→0x01→0x00→0xFF over 3 sampled cycles, leaving other channels static. Read ch2 → rd_cnt=3, rd_act=1. Read ch1 → rd_cnt=0. act_any=1 one cycle after the first change.
3. CNT_WIDTH=2; change ch0 on 5 consecutive primed cycles → rd_cnt=3 (saturated, no wrap to 1).
4. CLR_ON_READ=1, ch1 cnt=4; read ch1 in the same cycle as a ch1 change → rd_cnt=4. A second read of ch1 → rd_cnt=1, rd_act=1.
5. Assert clr in the same cycle as a ch3 change while a read of ch3 is pending (cnt=7):
   - Read returns 7; afterwards cnt=0 and act=0.
   - The next changed sample is priming only, so cnt stays 0.
6. NUM_CH=4, read rd_addr=9 → rd_valid=1 with all zero data. Assert rst while rd_en=1 → rd_valid=0 and all outputs 0 on the next edge.

Source files
------------

// File: rtl/dummy_sink_mon_if.sv
// Read port of the dummy sink monitor: the co-sim host issues a read strobe
// with a channel index and receives the registered channel snapshot one
// cycle later.
interface dummy_sink_mon_if #(
    parameter int AW        = 4,
    parameter int CNT_WIDTH = 16,
    parameter int CH_WIDTH  = 8
) ();
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic                 rd_valid;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [CH_WIDTH-1:0]  rd_last;
    logic                 rd_act;

    // Host side: issues reads, consumes results.
    modport master (
        output rd_en,
        output rd_addr,
        input  rd_valid,
        input  rd_cnt,
        input  rd_last,
        input  rd_act
    );

    // Monitor side: serves reads.
    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_valid,
        output rd_cnt,
        output rd_last,
        output rd_act
    );
endinterface

// File: rtl/dummy_sink_mon.sv
// Dummy sink monitor: terminates unused wrapper inputs while keeping, per
// channel, a saturating change counter, a sticky activity flag and the last
// sampled value. The first sample after reset or clr only primes the
// comparison baseline. Results are read through a registered read port.
module dummy_sink_mon #(
    parameter int NUM_CH      = 4,
    parameter int CH_WIDTH    = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int CLR_ON_READ = 0,
    parameter int AW          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*CH_WIDTH-1:0] in,
    input  logic                       sample_en,
    input  logic                       clr,
    dummy_sink_mon_if.slave            rd,
    output logic                       act_any
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CH_WIDTH-1:0]  CH_ZERO  = {CH_WIDTH{1'b0}};

    // Channel state
    logic [CNT_WIDTH-1:0] cnt_r      [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_nxt_s  [NUM_CH];
    logic [CH_WIDTH-1:0]  last_r     [NUM_CH];
    logic [CH_WIDTH-1:0]  last_nxt_s [NUM_CH];
    logic [CH_WIDTH-1:0]  in_ch_s    [NUM_CH];
    logic [NUM_CH-1:0]    act_r;
    logic [NUM_CH-1:0]    act_nxt_s;
    logic [NUM_CH-1:0]    change_s;
    logic [NUM_CH-1:0]    rd_clear_s;
    logic                 primed_r;
    logic                 primed_nxt_s;
    logic                 act_any_r;

    // Read path
    logic [CNT_WIDTH-1:0] rd_cnt_sel_s;
    logic [CH_WIDTH-1:0]  rd_last_sel_s;
    logic                 rd_act_sel_s;
    logic                 rd_valid_r;
    logic [CNT_WIDTH-1:0] rd_cnt_r;
    logic [CH_WIDTH-1:0]  rd_last_r;
    logic                 rd_act_r;

    // Per-channel next state: baseline load, change detection with
    // saturation, clear-on-read (a same-cycle change restarts at 1) and clr,
    // which beats everything.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            in_ch_s[k]    = in[k*CH_WIDTH +: CH_WIDTH];
            cnt_nxt_s[k]  = cnt_r[k];
            act_nxt_s[k]  = act_r[k];
            last_nxt_s[k] = last_r[k];
            change_s[k]   = sample_en && primed_r && (in_ch_s[k] != last_r[k]);
            rd_clear_s[k] = (CLR_ON_READ != 0) && rd.rd_en && (rd.rd_addr == AW'(k));

            if (sample_en) begin
                last_nxt_s[k] = in_ch_s[k];
            end else begin
                last_nxt_s[k] = last_r[k];
            end

            if (clr) begin
                cnt_nxt_s[k] = CNT_ZERO;
                act_nxt_s[k] = 1'b0;
            end else if (change_s[k]) begin
                act_nxt_s[k] = 1'b1;
                if (rd_clear_s[k]) begin
                    cnt_nxt_s[k] = CNT_ONE;
                end else if (cnt_r[k] != CNT_MAX) begin
                    cnt_nxt_s[k] = cnt_r[k] + CNT_ONE;
                end else begin
                    cnt_nxt_s[k] = cnt_r[k];
                end
            end else if (rd_clear_s[k]) begin
                cnt_nxt_s[k] = CNT_ZERO;
                act_nxt_s[k] = 1'b0;
            end else begin
                cnt_nxt_s[k] = cnt_r[k];
                act_nxt_s[k] = act_r[k];
            end
        end
    end

    // Priming: the first sample after reset or clr only establishes the baseline.
    always_comb begin
        primed_nxt_s = primed_r;
        if (clr) begin
            primed_nxt_s = 1'b0;
        end else if (sample_en) begin
            primed_nxt_s = 1'b1;
        end else begin
            primed_nxt_s = primed_r;
        end
    end

    // Read mux over pre-update state; out-of-range indices select zeros.
    always_comb begin
        rd_cnt_sel_s  = CNT_ZERO;
        rd_last_sel_s = CH_ZERO;
        rd_act_sel_s  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd.rd_addr == AW'(k)) begin
                rd_cnt_sel_s  = cnt_r[k];
                rd_last_sel_s = last_r[k];
                rd_act_sel_s  = act_r[k];
            end else begin
                rd_cnt_sel_s  = rd_cnt_sel_s;
                rd_last_sel_s = rd_last_sel_s;
                rd_act_sel_s  = rd_act_sel_s;
            end
        end
    end

    // Channel state registers and the lagging activity summary.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_r[k]  <= CNT_ZERO;
                last_r[k] <= CH_ZERO;
            end
            act_r     <= {NUM_CH{1'b0}};
            primed_r  <= 1'b0;
            act_any_r <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_r[k]  <= cnt_nxt_s[k];
                last_r[k] <= last_nxt_s[k];
            end
            act_r     <= act_nxt_s;
            primed_r  <= primed_nxt_s;
            act_any_r <= |act_r;
        end
    end

    // Registered read result; data holds while no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_cnt_r   <= CNT_ZERO;
            rd_last_r  <= CH_ZERO;
            rd_act_r   <= 1'b0;
        end else begin
            rd_valid_r <= rd.rd_en;
            if (rd.rd_en) begin
                rd_cnt_r  <= rd_cnt_sel_s;
                rd_last_r <= rd_last_sel_s;
                rd_act_r  <= rd_act_sel_s;
            end
        end
    end

    assign rd.rd_valid = rd_valid_r;
    assign rd.rd_cnt   = rd_cnt_r;
    assign rd.rd_last  = rd_last_r;
    assign rd.rd_act   = rd_act_r;
    assign act_any     = act_any_r;

endmodule

// File: tb/tb_dummy_sink_mon.sv
// Scoreboard bench for dummy_sink_mon. Two instances: u0 with default
// parameters, u1 with a 2-bit counter and clear-on-read. Reads push the
// hand-computed expected snapshot into a per-instance queue; a negedge
// monitor pops and compares whenever rd_valid is seen.
module tb_dummy_sink_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in0, in1;
    logic        se0, se1, clr0, clr1;
    logic        act_any0, act_any1;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] cnt;
        logic [7:0]  last;
        logic        act;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    dummy_sink_mon_if #(.AW(4), .CNT_WIDTH(16), .CH_WIDTH(8)) bus0 ();
    dummy_sink_mon_if #(.AW(4), .CNT_WIDTH(2),  .CH_WIDTH(8)) bus1 ();

    dummy_sink_mon #(.NUM_CH(4), .CH_WIDTH(8), .CNT_WIDTH(16), .CLR_ON_READ(0), .AW(4)) u0 (
        .clk(clk), .rst(rst), .in(in0), .sample_en(se0), .clr(clr0), .rd(bus0), .act_any(act_any0)
    );

    dummy_sink_mon #(.NUM_CH(4), .CH_WIDTH(8), .CNT_WIDTH(2), .CLR_ON_READ(1), .AW(4)) u1 (
        .clk(clk), .rst(rst), .in(in1), .sample_en(se1), .clr(clr1), .rd(bus1), .act_any(act_any1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read0(input logic [3:0] a, input logic [31:0] c, input logic [7:0] l, input logic ac);
        exp_t e;
        e.cnt = c; e.last = l; e.act = ac;
        bus0.rd_en   = 1'b1;
        bus0.rd_addr = a;
        q0.push_back(e);
        tick();
        bus0.rd_en = 1'b0;
    endtask

    task automatic read1(input logic [3:0] a, input logic [31:0] c, input logic [7:0] l, input logic ac);
        exp_t e;
        e.cnt = c; e.last = l; e.act = ac;
        bus1.rd_en   = 1'b1;
        bus1.rd_addr = a;
        q1.push_back(e);
        tick();
        bus1.rd_en = 1'b0;
    endtask

    // Monitor for u0 read results
    always @(negedge clk) begin
        exp_t e;
        if (bus0.rd_valid === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd0_unexpected: got rd_valid=1 expected no pending read");
            end else begin
                e = q0.pop_front();
                chk("rd0_cnt",  32'(bus0.rd_cnt),  e.cnt);
                chk("rd0_last", 32'(bus0.rd_last), 32'(e.last));
                chk("rd0_act",  32'(bus0.rd_act),  32'(e.act));
            end
        end
    end

    // Monitor for u1 read results
    always @(negedge clk) begin
        exp_t e;
        if (bus1.rd_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd1_unexpected: got rd_valid=1 expected no pending read");
            end else begin
                e = q1.pop_front();
                chk("rd1_cnt",  32'(bus1.rd_cnt),  e.cnt);
                chk("rd1_last", 32'(bus1.rd_last), 32'(e.last));
                chk("rd1_act",  32'(bus1.rd_act),  32'(e.act));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in0 = 32'h0; in1 = 32'h0;
        se0 = 1'b0; se1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        bus0.rd_en = 1'b0; bus0.rd_addr = 4'h0;
        bus1.rd_en = 1'b0; bus1.rd_addr = 4'h0;
        tick();
        tick();
        chk("rst_rd_valid", 32'(bus0.rd_valid), 32'h0);
        chk("rst_rd_cnt",   32'(bus0.rd_cnt),   32'h0);
        chk("rst_rd_last",  32'(bus0.rd_last),  32'h0);
        chk("rst_rd_act",   32'(bus0.rd_act),   32'h0);
        chk("rst_act_any",  32'(act_any0),      32'h0);
        rst = 1'b0;

        // Priming: ch0 steady at 0x5A, no counts
        in0 = 32'h0000_005A; se0 = 1'b1;
        tick(); tick(); tick();
        se0 = 1'b0;
        read0(4'd0, 32'd0, 8'h5A, 1'b0);

        // ch2 toggles 00->01->00->FF, act_any lags one cycle
        se0 = 1'b1;
        in0 = 32'h0001_005A; tick();
        chk("act_any_lag", 32'(act_any0), 32'h0);
        in0 = 32'h0000_005A; tick();
        chk("act_any_set", 32'(act_any0), 32'h1);
        in0 = 32'h00FF_005A; tick();
        se0 = 1'b0;
        read0(4'd2, 32'd3, 8'hFF, 1'b1);
        read0(4'd1, 32'd0, 8'h00, 1'b0);

        // ch3 counts to 7, then clr + change + read in one cycle
        se0 = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            in0 = {8'(i), 24'hFF_005A};
            tick();
        end
        clr0 = 1'b1;
        in0 = 32'h08FF_005A;
        read0(4'd3, 32'd7, 8'h07, 1'b1);
        clr0 = 1'b0; se0 = 1'b0;
        read0(4'd3, 32'd0, 8'h08, 1'b0);
        chk("act_any_clr", 32'(act_any0), 32'h0);
        read0(4'd2, 32'd0, 8'hFF, 1'b0);
        se0 = 1'b1; in0 = 32'h09FF_005A; tick(); se0 = 1'b0;
        read0(4'd3, 32'd0, 8'h09, 1'b0);

        // u1: saturation at 3 with a 2-bit counter, then clear-on-read
        se1 = 1'b1; in1 = 32'h0; tick();
        for (int i = 1; i <= 5; i++) begin
            in1 = 32'(i);
            tick();
        end
        se1 = 1'b0;
        read1(4'd0, 32'd3, 8'h05, 1'b1);
        read1(4'd0, 32'd0, 8'h05, 1'b0);

        // u1: read of ch1 together with a ch1 change keeps the event
        se1 = 1'b1;
        in1 = 32'h0000_0105; tick();
        in1 = 32'h0000_0205; tick();
        in1 = 32'h0000_0305;
        read1(4'd1, 32'd2, 8'h02, 1'b1);
        se1 = 1'b0;
        read1(4'd1, 32'd1, 8'h03, 1'b1);
        read1(4'd1, 32'd0, 8'h03, 1'b0);

        // Out-of-range read, then reset during a read
        read0(4'd9, 32'd0, 8'h00, 1'b0);
        read0(4'd3, 32'd0, 8'h09, 1'b0);
        rst = 1'b1; bus0.rd_en = 1'b1; bus0.rd_addr = 4'd3;
        tick();
        chk("rstrd_valid", 32'(bus0.rd_valid), 32'h0);
        chk("rstrd_cnt",   32'(bus0.rd_cnt),   32'h0);
        chk("rstrd_last",  32'(bus0.rd_last),  32'h0);
        chk("rstrd_act",   32'(bus0.rd_act),   32'h0);
        chk("rstrd_any0",  32'(act_any0),      32'h0);
        chk("rstrd_any1",  32'(act_any1),      32'h0);
        chk("rstrd_valid1", 32'(bus1.rd_valid), 32'h0);
        bus0.rd_en = 1'b0; rst = 1'b0;
        read0(4'd3, 32'd0, 8'h00, 1'b0);

        tick(); tick();
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
